rib_arb_xbar: RTL and testbench

Parametrised successor of the fixed four-master/seven-slave RIB interconnect in the tinyriscv SoC. It connects `NUM_M` bus masters (core data port, core fetch port, JTAG, UART debug, …) to `NUM_S` memory-mapped slaves through a shared address/write-data path. A registered ownership lock, a tenure counter with preemption, and optional round-robin arbitration replace the purely combinational fixed-priority select. It also generates the core `hold_flag_o` and flags decode errors.

---
 rtl/rib_arb_xbar.sv | 177 +++++++++++++++++
 tb/tb_rib_arb_xbar.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rib_arb_xbar.sv
// ============================================================================
//  Module      : rib_arb_xbar
//  Description : Parametrised RIB interconnect. NUM_M masters share one
//                address/write-data path to NUM_S slaves. A registered
//                ownership lock with a saturating tenure counter and
//                preemption decides the one-hot grant. Fixed priority
//                (highest index wins) by default; round-robin arbitration
//                when the RIB_RR_EN macro is defined. Generates the core
//                hold flag and a one-cycle decode-error pulse.
//  Options     : `define RIB_RR_EN  -> round-robin arbitration with rr_ptr
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rib_arb_xbar #(
    parameter int                NUM_M     = 4,
    parameter int                NUM_S     = 8,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                SEL_W     = 4,
    parameter logic [NUM_M-1:0]  HOLD_MASK = NUM_M'(4'b1101),
    parameter int                MAX_HOLD  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_M-1:0]          m_req_i,
    input  logic [NUM_M-1:0]          m_we_i,
    input  logic [NUM_M*ADDR_W-1:0]   m_addr_i,
    input  logic [NUM_M*DATA_W-1:0]   m_data_i,
    output logic [NUM_M*DATA_W-1:0]   m_data_o,
    output logic [NUM_M-1:0]          m_gnt_o,
    output logic [ADDR_W-1:0]         s_addr_o,
    output logic [DATA_W-1:0]         s_data_o,
    output logic [NUM_S-1:0]          s_we_o,
    input  logic [NUM_S*DATA_W-1:0]   s_data_i,
    output logic                      hold_flag_o,
    output logic                      err_o
);

    localparam int         OW         = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;
    localparam logic [15:0] C_HOLD_LAST = 16'(MAX_HOLD - 1);

    logic [OW-1:0]     r_owner;
    logic              r_own_vld;
    logic [15:0]       r_cnt;

    logic [NUM_M-1:0]  w_others;
    logic [NUM_M-1:0]  w_cand;
    logic              w_preempt;
    logic              w_keep;
    logic              w_pick_vld;
    logic [OW-1:0]     w_pick;
    logic              w_gnt_vld;
    logic [OW-1:0]     w_gnt_idx;
    logic              w_owner_chg;
    logic [ADDR_W-1:0] w_addr;
    logic [SEL_W-1:0]  w_sel;
    logic              w_dec_err;

`ifdef RIB_RR_EN
    logic [OW-1:0]     r_rr_ptr;
`endif

    // Grant selection: keep the locked owner unless preempted, else arbitrate
    always_comb begin
        w_others          = m_req_i;
        w_others[r_owner] = 1'b0;
        w_preempt = (MAX_HOLD != 0) && r_own_vld && (r_cnt == C_HOLD_LAST)
                    && (|w_others);
        w_keep    = r_own_vld && m_req_i[r_owner] && !w_preempt;

        // A preempted owner sits out exactly this one selection
        w_cand = m_req_i;
        if (w_preempt) begin
            w_cand[r_owner] = 1'b0;
        end

        w_pick_vld = 1'b0;
        w_pick     = '0;
`ifdef RIB_RR_EN
        // Descending offset scan: the last hit is the closest to rr_ptr
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (w_cand[(int'(r_rr_ptr) + i) % NUM_M]) begin
                w_pick_vld = 1'b1;
                w_pick     = OW'((int'(r_rr_ptr) + i) % NUM_M);
            end
        end
`else
        // Ascending scan: the last hit is the highest requesting index
        for (int i = 0; i < NUM_M; i++) begin
            if (w_cand[i]) begin
                w_pick_vld = 1'b1;
                w_pick     = OW'(i);
            end
        end
`endif

        // Reset drops any grant immediately, even mid-transaction
        w_gnt_vld   = !rst && (w_keep || w_pick_vld);
        w_gnt_idx   = w_keep ? r_owner : w_pick;
        w_owner_chg = w_gnt_vld && !(r_own_vld && (w_gnt_idx == r_owner));
    end

    // Shared datapath: mux the granted master onto the slave side and back
    always_comb begin
        w_addr    = m_addr_i[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
        w_sel     = w_addr[ADDR_W-1 -: SEL_W];
        w_dec_err = w_gnt_vld && (int'(w_sel) >= NUM_S);

        m_gnt_o  = '0;
        s_we_o   = '0;
        s_addr_o = '0;
        s_data_o = '0;
        m_data_o = '0;
        if (w_gnt_vld) begin
            for (int i = 0; i < NUM_M; i++) begin
                if (int'(w_gnt_idx) == i) begin
                    m_gnt_o[i] = 1'b1;
                end
            end
            s_addr_o                      = w_addr;
            s_addr_o[ADDR_W-1 -: SEL_W]   = '0;
            s_data_o = m_data_i[int'(w_gnt_idx)*DATA_W +: DATA_W];
            // An undecoded slave index gets no strobe and returns zero data
            if (!w_dec_err) begin
                for (int j = 0; j < NUM_S; j++) begin
                    if (int'(w_sel) == j) begin
                        s_we_o[j] = m_we_i[w_gnt_idx] & m_req_i[w_gnt_idx];
                        m_data_o[int'(w_gnt_idx)*DATA_W +: DATA_W] =
                            s_data_i[j*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    assign hold_flag_o = |(m_gnt_o & HOLD_MASK);

    // Ownership lock, tenure counter and registered decode-error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner   <= '0;
            r_own_vld <= 1'b0;
            r_cnt     <= '0;
            err_o     <= 1'b0;
        end else begin
            err_o <= w_dec_err;
            if (!w_gnt_vld) begin
                r_own_vld <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_own_vld <= 1'b1;
                r_owner   <= w_gnt_idx;
                if (w_owner_chg) begin
                    r_cnt <= '0;
                end else if (r_cnt != C_CNT_MAX) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
        end
    end

`ifdef RIB_RR_EN
    // Round-robin pointer moves just past each newly granted owner
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_owner_chg) begin
            r_rr_ptr <= (int'(w_gnt_idx) == NUM_M - 1) ? '0 : w_gnt_idx + OW'(1);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rib_arb_xbar.sv
// ============================================================================
//  Module      : tb_rib_arb_xbar
//  Description : Self-checking bench for rib_arb_xbar. u_dut (NUM_S=7,
//                MAX_HOLD=16) runs a table of single-cycle vectors plus
//                lock, reset and arbitration-order sequences; u_pre
//                (NUM_S=8, MAX_HOLD=4) shares the master inputs and covers
//                tenure preemption.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rib_arb_xbar;

    localparam int NM = 4;
    localparam int NS = 7;
    localparam int NP = 8;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NM-1:0]          m_req;
    logic [NM-1:0]          m_we;
    logic [NM-1:0][AW-1:0]  m_addr;
    logic [NM-1:0][DW-1:0]  m_wdata;
    logic [NS*DW-1:0]       s_rdata;
    logic [NP*DW-1:0]       p_srdata;

    logic [NM*DW-1:0]       m_rdata;
    logic [NM-1:0]          m_gnt;
    logic [AW-1:0]          s_addr;
    logic [DW-1:0]          s_wdata;
    logic [NS-1:0]          s_we;
    logic                   hold;
    logic                   err;

    logic [NM*DW-1:0]       p_rdata;
    logic [NM-1:0]          p_gnt;
    logic [AW-1:0]          p_addr;
    logic [DW-1:0]          p_wdata;
    logic [NP-1:0]          p_we;
    logic                   p_hold;
    logic                   p_err;

    rib_arb_xbar #(.NUM_S(NS), .MAX_HOLD(16)) u_dut (
        .clk(clk), .rst(rst),
        .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_data_i(m_wdata),
        .m_data_o(m_rdata), .m_gnt_o(m_gnt),
        .s_addr_o(s_addr), .s_data_o(s_wdata), .s_we_o(s_we),
        .s_data_i(s_rdata), .hold_flag_o(hold), .err_o(err)
    );

    rib_arb_xbar #(.NUM_S(NP), .MAX_HOLD(4)) u_pre (
        .clk(clk), .rst(rst),
        .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_data_i(m_wdata),
        .m_data_o(p_rdata), .m_gnt_o(p_gnt),
        .s_addr_o(p_addr), .s_data_o(p_wdata), .s_we_o(p_we),
        .s_data_i(p_srdata), .hold_flag_o(p_hold), .err_o(p_err)
    );

    typedef struct {
        logic [3:0]        req;
        logic [3:0]        we;
        logic [3:0][31:0]  addr;
        logic [3:0]        gnt;
        logic [6:0]        swe;
        logic [31:0]       saddr;
        logic [31:0]       sdata;
        logic [31:0]       rd;
        logic              hold;
        logic              err;
    } vec_t;

    vec_t vecs[9];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [31:0] D0 = 32'h0BAD_F00D;
    localparam logic [31:0] D1 = 32'hDEAD_BEEF;
    localparam logic [31:0] D2 = 32'h1234_5678;
    localparam logic [31:0] D3 = 32'hCAFE_F00D;

    function automatic vec_t mkv(input logic [3:0] req, input logic [3:0] we,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] a2, input logic [31:0] a3,
                                 input logic [3:0] gnt, input logic [6:0] swe,
                                 input logic [31:0] saddr, input logic [31:0] sdata,
                                 input logic [31:0] rd, input logic hold,
                                 input logic e);
        vec_t v;
        v.req = req; v.we = we;
        v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2; v.addr[3] = a3;
        v.gnt = gnt; v.swe = swe; v.saddr = saddr; v.sdata = sdata;
        v.rd = rd; v.hold = hold; v.err = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] we,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] a3);
        @(negedge clk);
        m_req = req; m_we = we;
        m_addr[0] = a0; m_addr[1] = a1; m_addr[2] = a2; m_addr[3] = a3;
        #1;
    endtask

    initial begin
        logic [127:0] exp_md;
        logic [3:0]   pending;
        logic [3:0]   order[5];
        logic [3:0]   first_pre;
        logic [3:0]   second_pre;
        logic [3:0]   e;

        m_wdata[0] = D0; m_wdata[1] = D1; m_wdata[2] = D2; m_wdata[3] = D3;
        for (int j = 0; j < NS; j++) s_rdata[j*DW +: DW]  = 32'hA000_0000 + j;
        for (int j = 0; j < NP; j++) p_srdata[j*DW +: DW] = 32'hB000_0000 + j;

        //               req      we       a0            a1            a2            a3            gnt      swe          saddr         sdata rd            hold  err
        vecs[0] = mkv(4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0,        32'h0,        4'b0000, 7'b0000000, 32'h0,        32'h0, 32'h0,        1'b0, 1'b0);
        vecs[1] = mkv(4'b0010, 4'b0010, 32'h0,        32'h1000_0004,32'h0,        32'h0,        4'b0010, 7'b0000010, 32'h0000_0004, D1,   32'hA000_0001,1'b0, 1'b0);
        vecs[2] = mkv(4'b0010, 4'b0000, 32'h0,        32'h1000_0004,32'h0,        32'h0,        4'b0010, 7'b0000000, 32'h0000_0004, D1,   32'hA000_0001,1'b0, 1'b0);
        vecs[3] = mkv(4'b0101, 4'b0100, 32'h0000_0008,32'h0,        32'h2000_0010,32'h0,        4'b0100, 7'b0000100, 32'h0000_0010, D2,   32'hA000_0002,1'b1, 1'b0);
        vecs[4] = mkv(4'b1101, 4'b0100, 32'h0000_0008,32'h0,        32'h2000_0010,32'h6000_0000,4'b0100, 7'b0000100, 32'h0000_0010, D2,   32'hA000_0002,1'b1, 1'b0);
        vecs[5] = mkv(4'b0101, 4'b0100, 32'h0000_0008,32'h0,        32'h7000_0000,32'h0,        4'b0100, 7'b0000000, 32'h0,         D2,   32'h0,        1'b1, 1'b0);
        vecs[6] = mkv(4'b0001, 4'b0000, 32'h0000_0008,32'h0,        32'h0,        32'h0,        4'b0001, 7'b0000000, 32'h0000_0008, D0,   32'hA000_0000,1'b1, 1'b1);
        vecs[7] = mkv(4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0,        32'h0,        4'b0000, 7'b0000000, 32'h0,        32'h0, 32'h0,        1'b0, 1'b0);
        vecs[8] = mkv(4'b1000, 4'b1000, 32'h0,        32'h0,        32'h0,        32'h6000_0000,4'b1000, 7'b1000000, 32'h0,         D3,   32'hA000_0006,1'b1, 1'b0);

`ifdef RIB_RR_EN
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100; order[3] = 4'b1000;
        first_pre = 4'b0010; second_pre = 4'b1000;
`else
        order[0] = 4'b1000; order[1] = 4'b0100; order[2] = 4'b0010; order[3] = 4'b0001;
        first_pre = 4'b1000; second_pre = 4'b0010;
`endif
        order[4] = order[0];

        // Reset state: a pending request must not be granted while rst is high
        rst = 1'b1;
        m_req = 4'b0100; m_we = 4'b0100; m_addr = '0; m_addr[2] = 32'h2000_0010;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_gnt",   128'(m_gnt),   128'(0));
        chk("reset_swe",   128'(s_we),    128'(0));
        chk("reset_saddr", 128'(s_addr),  128'(0));
        chk("reset_sdata", 128'(s_wdata), 128'(0));
        chk("reset_mdata", m_rdata,       128'(0));
        chk("reset_hold",  128'(hold),    128'(0));
        chk("reset_err",   128'(err),     128'(0));
        @(negedge clk);
        rst = 1'b0;

        // Table-driven single-cycle vectors
        for (int k = 0; k < 9; k++) begin
            drive(vecs[k].req, vecs[k].we, vecs[k].addr[0], vecs[k].addr[1],
                  vecs[k].addr[2], vecs[k].addr[3]);
            exp_md = '0;
            for (int i = 0; i < NM; i++)
                if (vecs[k].gnt[i]) exp_md[i*DW +: DW] = vecs[k].rd;
            chk($sformatf("v%0d_gnt", k),   128'(m_gnt),   128'(vecs[k].gnt));
            chk($sformatf("v%0d_swe", k),   128'(s_we),    128'(vecs[k].swe));
            chk($sformatf("v%0d_saddr", k), 128'(s_addr),  128'(vecs[k].saddr));
            chk($sformatf("v%0d_sdata", k), 128'(s_wdata), 128'(vecs[k].sdata));
            chk($sformatf("v%0d_mdata", k), m_rdata,       exp_md);
            chk($sformatf("v%0d_hold", k),  128'(hold),    128'(vecs[k].hold));
            chk($sformatf("v%0d_err", k),   128'(err),     128'(vecs[k].err));
        end

        // Lock held: master 0 keeps the bus while master 3 waits
        drive(4'b0000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int c = 0; c < 6; c++) begin
            drive(((c < 5) ? 4'b0001 : 4'b0000) | ((c >= 2) ? 4'b1000 : 4'b0000),
                  4'b0000, 32'h0, 32'h0, 32'h0, 32'h1000_0000);
            chk($sformatf("lock_c%0d_gnt", c), 128'(m_gnt),
                128'((c < 5) ? 4'b0001 : 4'b1000));
        end

        // Reset mid-transaction while master 2 owns the bus
        drive(4'b0100, 4'b0100, 32'h0, 32'h0, 32'h2000_0010, 32'h0);
        chk("mid_own_gnt", 128'(m_gnt), 128'(4'b0100));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt",   128'(m_gnt),   128'(0));
        chk("mid_rst_swe",   128'(s_we),    128'(0));
        chk("mid_rst_saddr", 128'(s_addr),  128'(0));
        chk("mid_rst_sdata", 128'(s_wdata), 128'(0));
        chk("mid_rst_mdata", m_rdata,       128'(0));
        chk("mid_rst_hold",  128'(hold),    128'(0));
        @(negedge clk); #1;
        chk("mid_rst_err",   128'(err),     128'(0));
        @(negedge clk);
        rst = 1'b0;
        // Tenure restarts at 0: u_pre keeps master 0 for exactly 4 cycles
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            m_req = (c == 0) ? 4'b0001 : 4'b0011; m_we = '0; m_addr = '0;
            #1;
            chk($sformatf("post_rst_c%0d_gnt", c), 128'(m_gnt), 128'(4'b0001));
            chk($sformatf("post_rst_c%0d_pgnt", c), 128'(p_gnt),
                128'((c < 4) ? 4'b0001 : 4'b0010));
        end

        // Arbitration order with single-cycle tenures, starting from reset
        @(negedge clk); rst = 1'b1; m_req = '0;
        @(negedge clk); rst = 1'b0;
        pending = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) pending = 4'b1111 & ~order[3];
            drive(pending, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
            chk($sformatf("order_k%0d_gnt", k), 128'(m_gnt), 128'(order[k]));
            pending = pending & ~order[k];
        end

        // Preemption on u_pre (MAX_HOLD=4): masters 1 and 3 alternate
        @(negedge clk); rst = 1'b1; m_req = '0;
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 16; c++) begin
            drive(4'b1010, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
            e = (((c / 4) % 2) == 0) ? first_pre : second_pre;
            chk($sformatf("pre_c%0d_gnt", c),  128'(p_gnt),  128'(e));
            chk($sformatf("pre_c%0d_hold", c), 128'(p_hold), 128'(e == 4'b1000));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
